// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: single-port memory arbiter/sequencer for fetch and load/store with 1-cycle read routing.
// Define MEM_ARB_RR_EN for round-robin conflicts; default is load/store priority with a fetch starvation counter.
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_r_enable,
  output logic              mem_w_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);
  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_IF   = 2'd1;
  localparam logic [1:0] RESP_LS   = 2'd2;
  logic [1:0] resp_q, resp_d;
  logic       if_win;
`ifdef MEM_ARB_RR_EN
  // lw_q = 1 means fetch won the last unflushed grant
  logic lw_q, lw_d;
  assign if_win = rst & if_req & ~if_flush & (~ls_req | ~lw_q);
  assign lw_d   = if_gnt ? 1'b1 : (ls_gnt & ~if_flush) ? 1'b0 : lw_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) lw_q <= 1'b1;
    else      lw_q <= lw_d;
  end
`else
  logic [3:0] starve_q, starve_d;
  assign if_win   = rst & if_req & ~if_flush & (~ls_req | starve_q == 4'(STARVE_MAX));
  assign starve_d = (~if_req | if_gnt) ? 4'd0 : (ls_gnt & ~if_flush) ? starve_q + 4'd1 : starve_q;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) starve_q <= 4'd0;
    else      starve_q <= starve_d;
  end
`endif
  assign if_gnt       = if_win;
  assign ls_gnt       = rst & ls_req & ~if_win;
  assign mem_r_enable = if_gnt | (ls_gnt & ~ls_we);
  assign mem_w_enable = ls_gnt & ls_we;
  assign mem_addr     = if_gnt ? if_addr : ls_gnt ? ls_addr : '0;
  assign mem_data_in  = ls_gnt ? ls_wdata : '0;
  assign resp_d       = if_gnt ? RESP_IF : (ls_gnt & ~ls_we) ? RESP_LS : RESP_NONE;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) resp_q <= RESP_NONE;
    else      resp_q <= resp_d;
  end
  assign if_rvalid = (resp_q == RESP_IF) & ~if_flush;
  assign if_rdata  = if_rvalid ? mem_data_out : '0;
  assign ls_rvalid = resp_q == RESP_LS;
  assign ls_rdata  = ls_rvalid ? mem_data_out : '0;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of grants, response routing, flush, starvation and reset.
module tb_mem_port_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req = 1'b0, if_flush = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
  logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
  logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_r_enable, mem_w_enable;
  logic [31:0] if_rdata, ls_rdata, mem_addr, mem_data_in;
  logic [31:0] mem_data_out = '0;
  logic [31:0] arr [0:63];
  logic [63:0] wr_mask = '0;
  int n_chk = 0, n_pass = 0;
  always #5 clk = ~clk;
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata), .ls_gnt(ls_gnt),
    .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
    .mem_r_enable(mem_r_enable), .mem_w_enable(mem_w_enable), .mem_addr(mem_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );
  // memory stub: unwritten words read as 0xA5000000 | address
  always @(posedge clk) begin
    if (mem_w_enable) begin
      arr[mem_addr[7:2]]     <= mem_data_in;
      wr_mask[mem_addr[7:2]] <= 1'b1;
    end
    if (mem_r_enable)
      mem_data_out <= wr_mask[mem_addr[7:2]] ? arr[mem_addr[7:2]] : (32'hA500_0000 | mem_addr);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic conflict(input int n, input int first_if_at, input int period);
    for (int i = 0; i < n; i++) begin
      if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; if_addr = 32'h10; ls_addr = 32'h20;
      #1;
      chk($sformatf("conf%0d_if", i), 32'(if_gnt), 32'((i % period) == first_if_at));
      chk($sformatf("conf%0d_ls", i), 32'(ls_gnt), 32'((i % period) != first_if_at));
      cyc();
    end
    if_req = 1'b0; ls_req = 1'b0;
  endtask
  initial begin
    if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h8;
    #2;
    chk("rst_if_gnt", 32'(if_gnt), 0);
    chk("rst_ls_gnt", 32'(ls_gnt), 0);
    chk("rst_r_en", 32'(mem_r_enable), 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_if_rvalid", 32'(if_rvalid), 0);
    if_req = 1'b0; ls_req = 1'b0;
    @(negedge clk); rst = 1'b1;
    cyc();
    // fetch-only stream
    for (int i = 0; i < 8; i++) begin
      if_req = 1'b1; if_addr = 32'(i * 4);
      #1;
      chk("fs_gnt", 32'(if_gnt), 1);
      chk("fs_addr", mem_addr, 32'(i * 4));
      chk("fs_w_en", 32'(mem_w_enable), 0);
      if (i > 0) begin
        chk("fs_rvalid", 32'(if_rvalid), 1);
        chk("fs_rdata", if_rdata, 32'hA500_0000 | 32'((i - 1) * 4));
      end
      cyc();
    end
    if_req = 1'b0;
    #1;
    chk("fs_last_rvalid", 32'(if_rvalid), 1);
    chk("fs_last_rdata", if_rdata, 32'hA500_001C);
    cyc();
    chk("fs_idle_rvalid", 32'(if_rvalid), 0);
    // store then load
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h40; ls_wdata = 32'hDEADBEEF;
    #1;
    chk("st_gnt", 32'(ls_gnt), 1);
    chk("st_w_en", 32'(mem_w_enable), 1);
    chk("st_r_en", 32'(mem_r_enable), 0);
    chk("st_data", mem_data_in, 32'hDEADBEEF);
    cyc();
    ls_we = 1'b0;
    #1;
    chk("ld_r_en", 32'(mem_r_enable), 1);
    chk("st_no_rvalid", 32'(ls_rvalid), 0);
    cyc();
    ls_req = 1'b0;
    #1;
    chk("ld_rvalid", 32'(ls_rvalid), 1);
    chk("ld_rdata", ls_rdata, 32'hDEADBEEF);
    chk("ld_if_rvalid", 32'(if_rvalid), 0);
    cyc();
    // continuous conflict
`ifdef MEM_ARB_RR_EN
    conflict(10, 0, 2);
`else
    conflict(10, 4, 5);
`endif
    cyc();
    // fetch at N, flush at N+1 with a load granted
    if_req = 1'b1; if_addr = 32'h30;
    #1;
    chk("fl_pre_gnt", 32'(if_gnt), 1);
    cyc();
    if_flush = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h44;
    #1;
    chk("fl_if_rvalid", 32'(if_rvalid), 0);
    chk("fl_if_rdata", if_rdata, 0);
    chk("fl_if_gnt", 32'(if_gnt), 0);
    chk("fl_ls_gnt", 32'(ls_gnt), 1);
    cyc();
    if_flush = 1'b0; if_req = 1'b0; ls_req = 1'b0;
    #1;
    chk("fl_ls_rvalid", 32'(ls_rvalid), 1);
    chk("fl_ls_rdata", ls_rdata, 32'hA500_0044);
    chk("fl_if_rvalid2", 32'(if_rvalid), 0);
    cyc();
`ifndef MEM_ARB_RR_EN
    // flush at STARVE_MAX: load/store granted, counter held
    conflict(4, 99, 100);
    if_req = 1'b1; ls_req = 1'b1; if_flush = 1'b1;
    #1;
    chk("sm_fl_if", 32'(if_gnt), 0);
    chk("sm_fl_ls", 32'(ls_gnt), 1);
    cyc();
    if_flush = 1'b0;
    #1;
    chk("sm_after_if", 32'(if_gnt), 1);
    chk("sm_after_ls", 32'(ls_gnt), 0);
    cyc();
    if_req = 1'b0; ls_req = 1'b0;
    cyc();
`endif
    // reset with a load outstanding and counter non-zero
    if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0; ls_addr = 32'h48;
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("mr_ls_rvalid", 32'(ls_rvalid), 0);
    chk("mr_ls_rdata", ls_rdata, 0);
    chk("mr_if_gnt", 32'(if_gnt), 0);
    chk("mr_ls_gnt", 32'(ls_gnt), 0);
    chk("mr_addr", mem_addr, 0);
    cyc();
    @(negedge clk);
    if_req = 1'b0; ls_req = 1'b0; rst = 1'b1;
    cyc();
    chk("mr_post_ls_rvalid", 32'(ls_rvalid), 0);
    chk("mr_post_if_rvalid", 32'(if_rvalid), 0);
`ifdef MEM_ARB_RR_EN
    conflict(4, 1, 2);
`else
    conflict(5, 4, 5);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
